// File: rtl/fifo_pkg.sv
// Shared helpers for the fifo block: pointer width and the o_data reset value.
package fifo_pkg;

    localparam int unsigned ODATA_RST = 0;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_if.sv
// Producer/consumer handshake and status bundle for the fifo block.
interface fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wren;
    logic                  rden;
    logic [DATA_WIDTH-1:0] i_data;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  full;
    logic                  empty;

    modport master (
        output wren, rden, i_data,
        input  o_data, full, empty
    );

    modport slave (
        input  wren, rden, i_data,
        output o_data, full, empty
    );
endinterface

// File: rtl/fifo_mem.sv
// Dual-port register array: synchronous write, combinational read address.
module fifo_mem #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 3
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Storage is deliberately left unreset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fifo.sv
// fifo top: pointers, occupancy count, flags and the registered read port.
// Build option FIFO_ZERO_ON_EMPTY_READ_EN: a read request while empty clears o_data.
module fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    fifo_if.slave bus
);
    localparam int AW = ptr_width(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_odata;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_wr_acc = bus.wren && !w_full;
    assign w_rd_acc = bus.rden && !w_empty;

    fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr),
        .i_wdata (bus.i_data),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    // Note: rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_odata <= DATA_WIDTH'(ODATA_RST);
        end else if (w_rd_acc) begin
            r_odata <= w_rdata;
`ifdef FIFO_ZERO_ON_EMPTY_READ_EN
        end else if (bus.rden) begin
            r_odata <= '0;
`endif
        end
    end

    assign bus.o_data = r_odata;
    assign bus.full   = w_full;
    assign bus.empty  = w_empty;
endmodule

// File: tb/tb_fifo.sv
// Testbench for fifo (DEPTH=4, DATA_WIDTH=16): directed steps plus random traffic vs a queue model.
module tb_fifo;
    localparam int DEPTH = 4;
    localparam int DW    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_o = '0;

    fifo_if #(.DATA_WIDTH(DW)) bus ();

    fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".o_data"}, bus.o_data, exp_o);
        check({tag, ".empty"}, {15'd0, bus.empty}, {15'd0, q.size() == 0});
        check({tag, ".full"}, {15'd0, bus.full}, {15'd0, q.size() == DEPTH});
    endtask

    // Called at a falling edge: drive, take one rising edge, update the model, check at the next falling edge.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
        logic wr_ok, rd_ok;
        bus.wren   = w;
        bus.rden   = r;
        bus.i_data = d;
        wr_ok = w && (q.size() < DEPTH);
        rd_ok = r && (q.size() > 0);
        @(posedge clk);
        if (rd_ok) exp_o = q.pop_front();
`ifdef FIFO_ZERO_ON_EMPTY_READ_EN
        else if (r) exp_o = '0;
`endif
        if (wr_ok) q.push_back(d);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic mid_reset(input string tag);
        bus.wren = 1'b0;
        bus.rden = 1'b0;
        #2 rst = 1'b1;
        #1;
        q.delete();
        exp_o = '0;
        check_all(tag);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all({tag, ".after"});
    endtask

    initial begin
        logic [DW-1:0] d;
        bus.wren   = 1'b0;
        bus.rden   = 1'b0;
        bus.i_data = '0;
        #3;
        check_all("reset");
        rst = 1'b0;
        @(negedge clk);

        step(1'b1, 1'b0, 16'h00A5, "single_wr");
        step(1'b0, 1'b1, 16'h0000, "single_rd");
        check("single_rd.val", bus.o_data, 16'h00A5);
        step(1'b0, 1'b1, 16'h0000, "empty_rd");

        step(1'b1, 1'b0, 16'h003C, "fill0");
        step(1'b1, 1'b0, 16'h007E, "fill1");
        step(1'b1, 1'b0, 16'h1111, "fill2");
        step(1'b1, 1'b0, 16'h2222, "fill3");
        check("fill3.full_const", {15'd0, bus.full}, 16'd1);
        step(1'b1, 1'b0, 16'hFFFF, "overflow");

        step(1'b0, 1'b1, 16'h0000, "drain0");
        check("drain0.val", bus.o_data, 16'h003C);
        step(1'b0, 1'b1, 16'h0000, "drain1");
        step(1'b0, 1'b1, 16'h0000, "drain2");
        step(1'b0, 1'b1, 16'h0000, "drain3");
        check("drain3.val", bus.o_data, 16'h2222);

        step(1'b1, 1'b0, 16'h0100, "pre0");
        step(1'b1, 1'b0, 16'h0101, "pre1");
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 16'h0102 + 16'(i), "concurrent");
        end
        check("concurrent.val", bus.o_data, 16'h0105);
        step(1'b1, 1'b1, 16'h0200, "pre_reset");
        mid_reset("mid_reset");

        step(1'b1, 1'b1, 16'h0300, "post_reset_wr_on_empty");
        check("post_reset.val", bus.o_data, 16'h0000);

        for (int i = 0; i < 300; i++) begin
            d = 16'($urandom);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d, "random");
            if (i == 150) mid_reset("random_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fifo.md
# fifo

Synchronous single-clock first-in/first-out buffer with parameterised depth and data width. Words written with `wren` are returned in write order through a registered read port. `full` and `empty` status flags provide flow control. It sits between a producer and a consumer in the same clock domain, as a general-purpose elasticity buffer.

## Interface
- `DEPTH`, default 8: number of storage entries; power of two, ≥ 2.
- `DATA_WIDTH`, default 8: width of each data word in bits.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-high reset; asserted = 1 resets immediately, independent of `clk`.
- `wren`  in  1  write request; `i_data` is stored on the rising edge when accepted.
- `rden`  in  1  read request; the head word is loaded into `o_data` on the rising edge when accepted.
- `i_data`  in  `DATA_WIDTH`  write data.
- `o_data`  out  `DATA_WIDTH`  registered read data.
- `full`  out  1  high when `DEPTH` words are stored.
- `empty`  out  1  high when no words are stored.

## Operation
- Storage: `DEPTH`-entry array, write pointer, read pointer and occupancy count.
  - Pointer width is `$clog2(DEPTH)`; pointers wrap modulo `DEPTH`.
  - Count width is `$clog2(DEPTH)+1`.
- Write is accepted iff `wren && !full`.
  - Accepted: the array entry at the write pointer takes `i_data` and the write pointer increments.
  - Write while full: dropped; no state changes.
- Read is accepted iff `rden && !empty`.
  - Accepted: `o_data` takes the entry at the read pointer and the read pointer increments.
  - Read while empty: no pointer or count change; `o_data` follows the Configuration rule.
- Simultaneous `wren` and `rden`:
  - Neither full nor empty: both accepted; count unchanged.
  - Empty: only the write is accepted.
  - Full: only the read is accepted; the write is dropped.
- Flags are decoded combinationally from the registered count:
  - `empty` = (count == 0).
  - `full` = (count == `DEPTH`).
- `o_data` holds its last value whenever no read is accepted.

## Timing
- Reset values: both pointers 0, count 0, `o_data` 0, `empty` 1, `full` 0. Array contents are not reset.
- Reset mid-operation: all stored data is discarded and the FIFO is empty immediately.
- Write-to-flag latency is one edge: `empty` falls after the rising edge that accepts the first write.
- Read latency is one edge: `o_data` is valid after the rising edge that accepts `rden`, and is stable for sampling at the following falling edge.
- Minimum write-to-read latency: a word written on edge N can be read on edge N+1.
- Flags update on the same edge as the pointer/count change. There is no look-ahead (almost-full/almost-empty) flag.

## Configuration
- `FIFO_ZERO_ON_EMPTY_READ_EN`:
  - Defined: a read request while empty loads `o_data` with 0.
  - Undefined: a read request while empty leaves `o_data` unchanged.
  - Pointers, count and flags behave identically in both builds.

## Structure
- `fifo_pkg` package: a pointer-width helper function wrapping `$clog2`, and a reset-value constant for `o_data`.
- One sub-module, `fifo_mem`: a dual-port register array with a synchronous write port and a combinational read address.
- The top level holds the pointers, count, flags and the `o_data` register.

## Test plan
Use `DEPTH`=4, `DATA_WIDTH`=16 throughout.

1. Reset: assert `rst_n`=1 mid-clock → immediately `empty`=1, `full`=0, `o_data`=0x0000.
2. Single word: write 0x00A5 for one edge, then `rden` for one edge → `o_data`=0x00A5 at the next falling edge; `empty`=1 afterwards.
3. Empty read: `rden` with the FIFO empty → `o_data` stays 0x00A5 (0x0000 with `FIFO_ZERO_ON_EMPTY_READ_EN`); count stays 0.
4. Fill and overflow:
   - Write 0x003C, 0x007E, 0x1111, 0x2222 → `full`=1 after the 4th edge.
   - A further write of 0xFFFF → ignored; `full` stays 1.
5. Drain in order: continuous `rden` → `o_data` sequence 0x003C, 0x007E, 0x1111, 0x2222 on successive edges; `empty`=1 after the 4th read; `full` clears after the 1st read.
6. Concurrent traffic and wrap-around:
   - With 2 words stored, hold `wren`=`rden`=1 for 6 edges with incrementing data → count remains 2, output order preserved across pointer wrap.
   - Assert reset during this traffic → FIFO empty immediately.
